// File: rtl/dmem_responder_pkg.sv
// Shared load/store constants and helpers: width codes, store-lane merge
// and load extension (the extension encoding is shared with the CPU).
package dmem_responder_pkg;

   localparam logic [2:0] LSU_LB  = 3'd0;
   localparam logic [2:0] LSU_LH  = 3'd1;
   localparam logic [2:0] LSU_LW  = 3'd2;
   localparam logic [2:0] LSU_LBU = 3'd4;
   localparam logic [2:0] LSU_LHU = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_ACCESS,
      S_MERGE,
      S_RESP
   } state_t;

   // Registered copy of an accepted request; the word address is held
   // separately because its width follows the array depth.
   typedef struct packed {
      logic        we;
      logic [2:0]  op;
      logic [1:0]  lane;
      logic [31:0] wdata;
   } mem_req_t;

   // Replace the addressed byte or halfword of old with the low bits of wdata.
   function automatic logic [31:0] lsu_merge(input logic [31:0] old,
                                             input logic [31:0] wdata,
                                             input logic [2:0]  op,
                                             input logic [1:0]  lane);
      logic [31:0] res;
      res = old;
      case (op)
         LSU_LB: res[{lane, 3'b000} +: 8] = wdata[7:0];
         LSU_LH: begin
            if (lane[1]) res[31:16] = wdata[15:0];
            else         res[15:0]  = wdata[15:0];
         end
         default: res = wdata;
      endcase
      return res;
   endfunction

   // Select the addressed lane of word and sign/zero-extend it.
   function automatic logic [31:0] lsu_extend(input logic [31:0] word,
                                              input logic [2:0]  op,
                                              input logic [1:0]  lane);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] res;
      b = word[{lane, 3'b000} +: 8];
      h = lane[1] ? word[31:16] : word[15:0];
      case (op)
         LSU_LB:  res = {{24{b[7]}}, b};
         LSU_LBU: res = {24'd0, b};
         LSU_LH:  res = {{16{h[15]}}, h};
         LSU_LHU: res = {16'd0, h};
         default: res = word;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response channels between a load/store unit and the data memory.
interface dmem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_op, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_op, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_array.sv
// Word-organised storage: synchronous write, registered read, no reset.
module dmem_array #(
   parameter int ADDR_W = 7
) (
   input  logic              clk,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata
);

   logic [31:0] mem [0:(1<<ADDR_W)-1];

   // Write and read share one address; a read in a write cycle sees old data.
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      if (re) rdata <= mem[addr];
   end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with programmable wait states,
// read-modify-write sub-word stores and error screening at acceptance.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int ADDR_W  = 7,
   parameter int LATENCY = 1
) (
   input  logic             clk,
   input  logic             rst,
   dmem_responder_if.slave  bus
);

   localparam bit         HAS_WAIT = (LATENCY > 0);
   localparam logic [2:0] CNT_INIT = HAS_WAIT ? 3'(LATENCY - 1) : 3'd0;

   state_t            state, state_nxt;
   logic [2:0]        cnt, cnt_nxt;
   mem_req_t          req_q;
   logic [ADDR_W-1:0] waddr_q;
   logic              err_q;

   logic              accept;
   logic              illegal, misaligned, out_of_range, acc_err;
   logic              arr_we, arr_re;
   logic [31:0]       arr_wdata, arr_rdata;

   assign accept = bus.req_valid & (state == S_IDLE);

   // Screen the incoming request; a rejected one never touches the array.
   always_comb begin
      illegal      = (bus.req_op == 3'd3) | (bus.req_op == 3'd6) | (bus.req_op == 3'd7) |
                     (bus.req_we & ((bus.req_op == LSU_LBU) | (bus.req_op == LSU_LHU)));
      misaligned   = (((bus.req_op == LSU_LH) | (bus.req_op == LSU_LHU)) & bus.req_addr[0]) |
                     ((bus.req_op == LSU_LW) & (bus.req_addr[1:0] != 2'b00));
      out_of_range = |(bus.req_addr >> (ADDR_W + 2));
      acc_err      = illegal | misaligned | out_of_range;
   end

   // State and wait counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         cnt   <= 3'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Capture the request and its screening result at acceptance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_q   <= '0;
         waddr_q <= '0;
         err_q   <= 1'b0;
      end else if (accept) begin
         req_q.we    <= bus.req_we;
         req_q.op    <= bus.req_op;
         req_q.lane  <= bus.req_addr[1:0];
         req_q.wdata <= bus.req_wdata;
         waddr_q     <= bus.req_addr[ADDR_W+1:2];
         err_q       <= acc_err;
      end
   end

   // Next state, counter and array controls. Writes are gated by state, so a
   // reset that lands in MERGE drops the pending write.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      arr_we    = 1'b0;
      arr_re    = 1'b0;
      arr_wdata = req_q.wdata;
      case (state)
         S_IDLE: begin
            if (accept) begin
               if (acc_err) begin
                  state_nxt = S_RESP;
               end else if (HAS_WAIT) begin
                  state_nxt = S_WAIT;
                  cnt_nxt   = CNT_INIT;
               end else begin
                  state_nxt = S_ACCESS;
               end
            end
         end
         S_WAIT: begin
            if (cnt == 3'd0) state_nxt = S_ACCESS;
            else             cnt_nxt   = cnt - 3'd1;
         end
         S_ACCESS: begin
            arr_re = 1'b1;
            if (req_q.we && req_q.op == LSU_LW) begin
               arr_we    = 1'b1;
               state_nxt = S_RESP;
            end else if (req_q.we) begin
               state_nxt = S_MERGE;
            end else begin
               state_nxt = S_RESP;
            end
         end
         S_MERGE: begin
            arr_we    = 1'b1;
            arr_wdata = lsu_merge(arr_rdata, req_q.wdata, req_q.op, req_q.lane);
            state_nxt = S_RESP;
         end
         S_RESP: begin
            if (bus.rsp_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   dmem_array #(.ADDR_W(ADDR_W)) u_array (
      .clk   (clk),
      .we    (arr_we),
      .re    (arr_re),
      .addr  (waddr_q),
      .wdata (arr_wdata),
      .rdata (arr_rdata)
   );

   // Response fields only carry data in RESP; the read register holds the
   // word steady while the requester stalls.
   assign bus.req_ready = (state == S_IDLE);
   assign bus.rsp_valid = (state == S_RESP);
   assign bus.rsp_err   = (state == S_RESP) & err_q;
   assign bus.rsp_rdata = ((state == S_RESP) && !err_q && !req_q.we)
                          ? lsu_extend(arr_rdata, req_q.op, req_q.lane) : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus random
// traffic compared against a word-array reference model.
module tb_dmem_responder;

   localparam int ADDR_W = 7;
   localparam int LAT    = 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dmem_responder_if bus();

   dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int nvec = 0;
   int nbad = 0;

   logic [31:0] mdl [0:(1<<ADDR_W)-1];

   function automatic bit mdl_err(input bit we, input int op, input logic [31:0] a);
      if (op == 3 || op > 5) return 1'b1;
      if (we && op >= 4) return 1'b1;
      if ((op == 1 || op == 5) && a[0]) return 1'b1;
      if (op == 2 && a[1:0] != 2'b00) return 1'b1;
      if (a >= 32'(4 * (1 << ADDR_W))) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] mdl_load(input logic [31:0] w, input int op, input logic [1:0] lo);
      logic [31:0] bv, hv;
      bv = (w >> (8 * lo)) & 32'hFF;
      hv = (w >> (16 * lo[1])) & 32'hFFFF;
      case (op)
         0: return (bv >= 128) ? bv - 32'd256 : bv;
         4: return bv;
         1: return (hv >= 32768) ? hv - 32'd65536 : hv;
         5: return hv;
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] mdl_store(input logic [31:0] w, input int op,
                                             input logic [1:0] lo, input logic [31:0] d);
      logic [31:0] m;
      case (op)
         0: begin m = 32'hFF << (8 * lo);      return (w & ~m) | ((d & 32'hFF) << (8 * lo)); end
         1: begin m = 32'hFFFF << (16 * lo[1]); return (w & ~m) | ((d & 32'hFFFF) << (16 * lo[1])); end
         default: return d;
      endcase
   endfunction

   // Drive one request starting in IDLE, wait (bounded) for the response,
   // optionally stall it for hold cycles, then accept it. lat counts cycles
   // after the acceptance edge; returns #1 into the following cycle.
   task automatic xact(input bit we, input int op, input logic [31:0] a, input logic [31:0] d,
                       input int hold, output logic [31:0] rd, output bit er, output int lat,
                       output bit stable, output time t_acc);
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_op    = 3'(op);
      bus.req_addr  = a;
      bus.req_wdata = d;
      @(posedge clk);
      t_acc = $time;
      #1 bus.req_valid = 1'b0;
      lat = 1;
      while (!bus.rsp_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      rd = bus.rsp_rdata;
      er = bus.rsp_err;
      stable = 1'b1;
      repeat (hold) begin
         @(posedge clk); #1;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== rd || bus.rsp_err !== er ||
             bus.req_ready !== 1'b0) stable = 1'b0;
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      nvec++;
      if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'd0) begin
         nbad++;
         $display("FAIL reset_outputs: got valid=%b err=%b rdata=%h, want 0/0/0",
                  bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
      end
      rst = 1'b0;
      #1;
      nvec++;
      if (bus.req_ready !== 1'b1) begin
         nbad++;
         $display("FAIL reset_ready: got %b want 1", bus.req_ready);
      end
   endtask

   task automatic test_sw_lw();
      logic [31:0] rd; bit er, st; int lat; time t;
      xact(1'b1, 2, 32'h10, 32'hDEADBEEF, 0, rd, er, lat, st, t);
      mdl[4] = 32'hDEADBEEF;
      nvec++;
      if (lat != LAT + 2 || er !== 1'b0 || rd !== 32'd0) begin
         nbad++;
         $display("FAIL sw_rsp: got lat=%0d err=%b rdata=%h, want %0d/0/0", lat, er, rd, LAT + 2);
      end
      xact(1'b0, 2, 32'h10, 32'h0, 0, rd, er, lat, st, t);
      nvec++;
      if (lat != LAT + 2 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin
         nbad++;
         $display("FAIL lw_rsp: got lat=%0d err=%b rdata=%h, want %0d/0/deadbeef", lat, er, rd, LAT + 2);
      end
   endtask

   task automatic test_errors();
      logic [31:0] rd; bit er, st; int lat; time t;
      bit          ewe [4]  = '{1'b0, 1'b1, 1'b0, 1'b0};
      int          eop [4]  = '{2, 1, 2, 3};
      logic [31:0] eadr [4] = '{32'h12, 32'h13, 32'h200, 32'h10};
      for (int i = 0; i < 4; i++) begin
         xact(ewe[i], eop[i], eadr[i], 32'hFFFF_FFFF, 0, rd, er, lat, st, t);
         nvec++;
         if (er !== 1'b1 || rd !== 32'd0 || lat != 1) begin
            nbad++;
            $display("FAIL err_case%0d: got err=%b rdata=%h lat=%0d, want 1/0/1", i, er, rd, lat);
         end
      end
      xact(1'b0, 2, 32'h10, 32'h0, 0, rd, er, lat, st, t);
      nvec++;
      if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
         nbad++;
         $display("FAIL err_no_update: got rdata=%h err=%b, want deadbeef/0", rd, er);
      end
   endtask

   task automatic test_sb();
      logic [31:0] rd; bit er, st; int lat; time t;
      xact(1'b1, 0, 32'h11, 32'h0000_007F, 0, rd, er, lat, st, t);
      mdl[4] = 32'hDEAD7FEF;
      nvec++;
      if (lat != LAT + 3 || er !== 1'b0) begin
         nbad++;
         $display("FAIL sb_rsp: got lat=%0d err=%b, want %0d/0", lat, er, LAT + 3);
      end
      xact(1'b0, 2, 32'h10, 32'h0, 0, rd, er, lat, st, t);
      nvec++;
      if (rd !== 32'hDEAD7FEF) begin
         nbad++;
         $display("FAIL sb_merge: got %h want dead7fef", rd);
      end
   endtask

   task automatic test_extend();
      logic [31:0] rd; bit er, st; int lat; time t;
      int          xop [4]  = '{0, 4, 1, 5};
      logic [31:0] xadr [4] = '{32'h20, 32'h20, 32'h22, 32'h22};
      logic [31:0] xexp [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001};
      xact(1'b1, 2, 32'h20, 32'h8001F080, 0, rd, er, lat, st, t);
      mdl[8] = 32'h8001F080;
      for (int i = 0; i < 4; i++) begin
         xact(1'b0, xop[i], xadr[i], 32'h0, 0, rd, er, lat, st, t);
         nvec++;
         if (rd !== xexp[i] || er !== 1'b0) begin
            nbad++;
            $display("FAIL extend_op%0d: got %h err=%b want %h", xop[i], rd, er, xexp[i]);
         end
      end
   endtask

   task automatic test_stall();
      logic [31:0] rd; bit er, st; int lat; time t;
      xact(1'b0, 2, 32'h20, 32'h0, 5, rd, er, lat, st, t);
      nvec++;
      if (st !== 1'b1 || rd !== 32'h8001F080) begin
         nbad++;
         $display("FAIL stall_hold: got stable=%b rdata=%h, want 1/8001f080", st, rd);
      end
      nvec++;
      if (bus.req_ready !== 1'b1) begin
         nbad++;
         $display("FAIL stall_release: got req_ready=%b want 1", bus.req_ready);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd; bit er, st; int lat; time t0, t1;
      xact(1'b0, 2, 32'h10, 32'h0, 0, rd, er, lat, st, t0);
      xact(1'b0, 2, 32'h20, 32'h0, 0, rd, er, lat, st, t1);
      nvec++;
      if ((t1 - t0) / 10 != LAT + 3 || rd !== 32'h8001F080) begin
         nbad++;
         $display("FAIL back_to_back: got period=%0d rdata=%h, want %0d/8001f080",
                  (t1 - t0) / 10, rd, LAT + 3);
      end
   endtask

   task automatic test_random();
      logic [31:0] rd, a, d, exp_rd; bit er, st, we, exp_er; int lat, op, exp_lat; time t;
      for (int w = 16; w < 24; w++) begin
         d = $urandom;
         xact(1'b1, 2, 32'(w * 4), d, 0, rd, er, lat, st, t);
         mdl[w] = d;
      end
      for (int i = 0; i < 80; i++) begin
         we = 1'($urandom_range(0, 1));
         op = $urandom_range(0, 7);
         d  = $urandom;
         if ($urandom_range(0, 9) == 0) a = $urandom | 32'h200;
         else                           a = 32'h40 + $urandom_range(0, 31);
         exp_er  = mdl_err(we, op, a);
         exp_rd  = 32'd0;
         exp_lat = exp_er ? 1 : ((we && op != 2) ? LAT + 3 : LAT + 2);
         if (!exp_er && we)  mdl[a[ADDR_W+1:2]] = mdl_store(mdl[a[ADDR_W+1:2]], op, a[1:0], d);
         if (!exp_er && !we) exp_rd = mdl_load(mdl[a[ADDR_W+1:2]], op, a[1:0]);
         xact(we, op, a, d, $urandom_range(0, 2), rd, er, lat, st, t);
         nvec++;
         if (rd !== exp_rd || er !== exp_er || lat != exp_lat || st !== 1'b1) begin
            nbad++;
            $display("FAIL rand%0d we=%b op=%0d a=%h: got rdata=%h err=%b lat=%0d st=%b, want %h/%b/%0d/1",
                     i, we, op, a, rd, er, lat, st, exp_rd, exp_er, exp_lat);
         end
      end
   endtask

   task automatic test_reset_merge();
      logic [31:0] rd; bit er, st; int lat; time t;
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_op    = 3'd0;
      bus.req_addr  = 32'h10;
      bus.req_wdata = 32'h0;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      repeat (LAT + 1) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      #1;
      nvec++;
      if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
         nbad++;
         $display("FAIL rst_merge_state: got valid=%b ready=%b, want 0/1", bus.rsp_valid, bus.req_ready);
      end
      xact(1'b0, 2, 32'h10, 32'h0, 0, rd, er, lat, st, t);
      nvec++;
      if (rd !== mdl[4]) begin
         nbad++;
         $display("FAIL rst_merge_word: got %h want %h", rd, mdl[4]);
      end
   endtask

   initial begin
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_op    = 3'd0;
      bus.req_addr  = 32'd0;
      bus.req_wdata = 32'd0;
      bus.rsp_ready = 1'b0;
      test_reset();
      test_sw_lw();
      test_errors();
      test_sb();
      test_extend();
      test_stall();
      test_back_to_back();
      test_random();
      test_reset_merge();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
